// File: rtl/audio_sample_framer_if.sv
// Bundle of audio sample framer signals.
// Sample side: sample_valid/left/right in, sample_ready/overflow out.
// Packet side: packet_request/ack in, packet_valid/audio_sample_word/
// sample_present/block_start out.
// Modport master drives the inputs (feeder + packet picker); slave is the framer.
interface audio_sample_framer_if #(
  parameter int unsigned AUDIO_BIT_WIDTH = 16
);
  logic                       sample_valid;
  logic [AUDIO_BIT_WIDTH-1:0] sample_left;
  logic [AUDIO_BIT_WIDTH-1:0] sample_right;
  logic                       sample_ready;
  logic                       overflow;
  logic                       packet_request;
  logic                       packet_valid;
  logic                       packet_ack;
  logic [191:0]               audio_sample_word;
  logic [3:0]                 sample_present;
  logic [3:0]                 block_start;

  modport master (
    output sample_valid, sample_left, sample_right, packet_request, packet_ack,
    input  sample_ready, overflow, packet_valid, audio_sample_word,
           sample_present, block_start
  );

  modport slave (
    input  sample_valid, sample_left, sample_right, packet_request, packet_ack,
    output sample_ready, overflow, packet_valid, audio_sample_word,
           sample_present, block_start
  );
endinterface

// File: rtl/audio_sample_framer.sv
// Audio sample framer: buffers stereo PCM samples in a FIFO and, when a
// data-island slot is offered, packs up to 4 MSB-aligned samples into a
// 192-bit payload tagged with per-slot present and IEC 60958 block-start flags.
// Ports:
//   clk_pixel  - pixel clock (only clock)
//   reset      - synchronous active-high reset
//   bus        - audio_sample_framer_if.slave (sample input, packet output)
module audio_sample_framer #(
  parameter int unsigned AUDIO_BIT_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH      = 8
) (
  input  logic                 clk_pixel,
  input  logic                 reset,
  audio_sample_framer_if.slave bus
);
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W      = PTR_W + 1;
  localparam int unsigned PAD_W      = 24 - AUDIO_BIT_WIDTH;
  localparam int unsigned SLOTS      = 4;
  localparam int unsigned ENTRY_W    = 48;
  localparam int unsigned LAST_FRAME = 191;

  typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

  state_t               state_q, state_d;
  logic [ENTRY_W-1:0]   mem_q [FIFO_DEPTH];
  logic [ENTRY_W-1:0]   mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [7:0]           frame_q, frame_d;
  logic [2:0]           n_q, n_d;
  logic [1:0]           slot_q, slot_d;
  logic                 sample_ready_q, sample_ready_d;
  logic                 overflow_q, overflow_d;
  logic                 packet_valid_q, packet_valid_d;
  logic [191:0]         word_q, word_d;
  logic [SLOTS-1:0]     present_q, present_d;
  logic [SLOTS-1:0]     block_q, block_d;

  logic                 full;
  logic                 push;
  logic                 pop;
  logic [23:0]          left_al;
  logic [23:0]          right_al;

  // MSB-align into 24-bit fields, zero-filling the low bits
  assign left_al  = 24'(bus.sample_left)  << PAD_W;
  assign right_al = 24'(bus.sample_right) << PAD_W;

  // Next-state logic for the packet FSM and the sample FIFO
  always_comb begin
    state_d        = state_q;
    mem_d          = mem_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    frame_d        = frame_q;
    n_d            = n_q;
    slot_d         = slot_q;
    overflow_d     = overflow_q;
    packet_valid_d = packet_valid_q;
    word_d         = word_q;
    present_d      = present_q;
    block_d        = block_q;
    pop            = 1'b0;
    push           = 1'b0;
    full           = (count_q == CNT_W'(FIFO_DEPTH));

    case (state_q)
      IDLE: begin
        // Snapshot n now so pushes during LOAD cannot lengthen the packet
        if (bus.packet_request && (count_q != '0)) begin
          n_d       = (count_q >= CNT_W'(SLOTS)) ? 3'd4 : 3'(count_q);
          slot_d    = 2'd0;
          word_d    = '0;
          present_d = '0;
          block_d   = '0;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        pop = 1'b1;
        for (int k = 0; k < int'(SLOTS); k++) begin
          if (slot_q == 2'(k)) begin
            word_d[k*int'(ENTRY_W) +: ENTRY_W] = mem_q[rd_ptr_q];
            present_d[k]                       = 1'b1;
            block_d[k]                         = (frame_q == 8'd0);
          end
        end
        frame_d = (frame_q == 8'(LAST_FRAME)) ? 8'd0 : frame_q + 8'd1;
        slot_d  = slot_q + 2'd1;
        if (({1'b0, slot_q} + 3'd1) == n_q) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        // First HOLD cycle raises valid; ack is only honoured once valid is up
        if (!packet_valid_q) begin
          packet_valid_d = 1'b1;
        end else if (bus.packet_ack) begin
          packet_valid_d = 1'b0;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A pop in the same cycle frees a slot, so a push while full is accepted
    push = bus.sample_valid && (!full || pop);
    if (push) begin
      mem_d[wr_ptr_q] = {right_al, left_al};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    if (bus.sample_valid && full && !pop) begin
      overflow_d = 1'b1;
    end
    sample_ready_d = (count_d != CNT_W'(FIFO_DEPTH));
  end

  // State registers
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state_q        <= IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      frame_q        <= '0;
      n_q            <= '0;
      slot_q         <= '0;
      sample_ready_q <= 1'b1;
      overflow_q     <= 1'b0;
      packet_valid_q <= 1'b0;
      word_q         <= '0;
      present_q      <= '0;
      block_q        <= '0;
    end else begin
      state_q        <= state_d;
      mem_q          <= mem_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      frame_q        <= frame_d;
      n_q            <= n_d;
      slot_q         <= slot_d;
      sample_ready_q <= sample_ready_d;
      overflow_q     <= overflow_d;
      packet_valid_q <= packet_valid_d;
      word_q         <= word_d;
      present_q      <= present_d;
      block_q        <= block_d;
    end
  end

  assign bus.sample_ready      = sample_ready_q;
  assign bus.overflow          = overflow_q;
  assign bus.packet_valid      = packet_valid_q;
  assign bus.audio_sample_word = word_q;
  assign bus.sample_present    = present_q;
  assign bus.block_start       = block_q;
endmodule

// File: tb/tb_audio_sample_framer.sv
// Self-checking bench for audio_sample_framer: scoreboard of aligned samples,
// model frame counter, plus small 20- and 24-bit instances for alignment.
module tb_audio_sample_framer;
  localparam int unsigned DEPTH = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  audio_sample_framer_if #(.AUDIO_BIT_WIDTH(16)) if16();
  audio_sample_framer_if #(.AUDIO_BIT_WIDTH(20)) if20();
  audio_sample_framer_if #(.AUDIO_BIT_WIDTH(24)) if24();

  audio_sample_framer #(.AUDIO_BIT_WIDTH(16), .FIFO_DEPTH(DEPTH)) dut16 (
    .clk_pixel(clk), .reset(reset), .bus(if16));
  audio_sample_framer #(.AUDIO_BIT_WIDTH(20), .FIFO_DEPTH(DEPTH)) dut20 (
    .clk_pixel(clk), .reset(reset), .bus(if20));
  audio_sample_framer #(.AUDIO_BIT_WIDTH(24), .FIFO_DEPTH(DEPTH)) dut24 (
    .clk_pixel(clk), .reset(reset), .bus(if24));

  int n_checks = 0;
  int n_errors = 0;

  logic [47:0] exp_q[$];
  int          model_count = 0;
  int          model_frame = 0;

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] align16(input logic [15:0] x);
    return {x, 8'h00};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    model_count = 0;
    model_frame = 0;
  endtask

  task automatic push16(input logic [15:0] l, input logic [15:0] r);
    bit acc;
    acc = (model_count < int'(DEPTH));
    if16.sample_valid = 1'b1;
    if16.sample_left  = l;
    if16.sample_right = r;
    step();
    if16.sample_valid = 1'b0;
    if (acc) begin
      exp_q.push_back({align16(r), align16(l)});
      model_count++;
    end
  endtask

  // Request a packet, check latency and payload against the scoreboard
  task automatic request16(input string tag, input bit do_ack);
    int n, lat;
    logic [191:0] ew;
    logic [3:0] ep, eb;
    n = (model_count < 4) ? model_count : 4;
    if16.packet_request = 1'b1;
    step();
    if16.packet_request = 1'b0;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!if16.packet_valid && lat < 30);
    check({tag, "_lat"}, 192'(lat), 192'(n + 1));
    if (!if16.packet_valid) return;
    ew = '0; ep = '0; eb = '0;
    for (int k = 0; k < n; k++) begin
      ew[k*48 +: 48] = exp_q.pop_front();
      ep[k] = 1'b1;
      eb[k] = (model_frame == 0);
      model_frame = (model_frame + 1) % 192;
    end
    model_count -= n;
    check({tag, "_word"}, if16.audio_sample_word, ew);
    check({tag, "_present"}, 192'(if16.sample_present), 192'(ep));
    check({tag, "_block"}, 192'(if16.block_start), 192'(eb));
    if (do_ack) begin
      if16.packet_ack = 1'b1;
      step();
      if16.packet_ack = 1'b0;
      check({tag, "_ackdrop"}, 192'(if16.packet_valid), 192'(0));
    end
  endtask

  task automatic pack_n(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      push16(16'($urandom), 16'($urandom));
    end
    request16(tag, 1'b1);
  endtask

  initial begin
    bit seen;
    int lat;

    reset = 1'b1;
    if16.sample_valid = 1'b1; if16.sample_left = 16'h5555; if16.sample_right = 16'haaaa;
    if16.packet_request = 1'b0; if16.packet_ack = 1'b0;
    if20.sample_valid = 1'b0; if20.sample_left = '0; if20.sample_right = '0;
    if20.packet_request = 1'b0; if20.packet_ack = 1'b0;
    if24.sample_valid = 1'b0; if24.sample_left = '0; if24.sample_right = '0;
    if24.packet_request = 1'b0; if24.packet_ack = 1'b0;
    repeat (3) step();

    // Reset values
    check("rst_ready", 192'(if16.sample_ready), 192'(1));
    check("rst_ovf", 192'(if16.overflow), 192'(0));
    check("rst_valid", 192'(if16.packet_valid), 192'(0));
    check("rst_word", if16.audio_sample_word, '0);
    check("rst_present", 192'(if16.sample_present), 192'(0));
    check("rst_block", 192'(if16.block_start), 192'(0));
    if16.sample_valid = 1'b0;
    reset = 1'b0;
    step();

    // Basic 16-bit packet
    push16(16'h1234, 16'habcd);
    check("first_push_ready", 192'(if16.sample_ready), 192'(1));
    push16(16'h0001, 16'hffff);
    push16(16'h7fff, 16'h8000);
    request16("basic", 1'b1);
    check("basic_slot0", 192'(if16.audio_sample_word[47:0]), 192'({24'habcd00, 24'h123400}));
    check("basic_slot3", 192'(if16.audio_sample_word[191:144]), 192'(0));

    // Empty request produces nothing
    if16.packet_request = 1'b1;
    step();
    if16.packet_request = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      step();
      if (if16.packet_valid) seen = 1'b1;
    end
    check("empty_novalid", 192'(seen), 192'(0));
    push16(16'h0042, 16'h0024);
    request16("after_empty", 1'b1);

    // Overflow: 9 back-to-back pushes into an 8-deep FIFO
    for (int i = 1; i <= 9; i++) begin
      push16(16'(i * 16'h0111), 16'(16'hf000 | i));
      if (i == 8) check("ovf_ready_full", 192'(if16.sample_ready), 192'(0));
    end
    check("ovf_sticky", 192'(if16.overflow), 192'(1));
    request16("ovf_a", 1'b1);
    request16("ovf_b", 1'b1);
    check("ovf_still", 192'(if16.overflow), 192'(1));
    check("ovf_ready_again", 192'(if16.sample_ready), 192'(1));

    // Block wrap: restart frame count, consume 190 samples
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_reset();
    check("wrap_ovf_cleared", 192'(if16.overflow), 192'(0));
    for (int i = 0; i < 47; i++) pack_n("wrap_fill", 4);
    pack_n("wrap_fill2", 2);
    pack_n("wrap_edge", 4);
    check("wrap_block_0100", 192'(if16.block_start), 192'(4'b0100));
    for (int i = 0; i < 48; i++) pack_n("wrap_next", 4);

    // 20-bit alignment
    if20.sample_valid = 1'b1; if20.sample_left = 20'habcde; if20.sample_right = 20'h12345;
    step();
    if20.sample_valid = 1'b0;
    if20.packet_request = 1'b1;
    step();
    if20.packet_request = 1'b0;
    lat = 0;
    do begin step(); lat++; end while (!if20.packet_valid && lat < 30);
    check("w20_lat", 192'(lat), 192'(2));
    check("w20_slot0", 192'(if20.audio_sample_word[47:0]), 192'({24'h123450, 24'habcde0}));
    if20.packet_ack = 1'b1;
    step();
    if20.packet_ack = 1'b0;

    // 24-bit alignment
    if24.sample_valid = 1'b1; if24.sample_left = 24'h123456; if24.sample_right = 24'hfedcba;
    step();
    if24.sample_valid = 1'b0;
    if24.packet_request = 1'b1;
    step();
    if24.packet_request = 1'b0;
    lat = 0;
    do begin step(); lat++; end while (!if24.packet_valid && lat < 30);
    check("w24_lat", 192'(lat), 192'(2));
    check("w24_slot0", 192'(if24.audio_sample_word[47:0]), 192'({24'hfedcba, 24'h123456}));
    if24.packet_ack = 1'b1;
    step();
    if24.packet_ack = 1'b0;

    // Reset during HOLD aborts the packet and empties the FIFO
    push16(16'h1111, 16'h2222);
    push16(16'h3333, 16'h4444);
    push16(16'h5555, 16'h6666);
    push16(16'h7777, 16'h8888);
    push16(16'h9999, 16'haaaa);
    request16("abort_pre", 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_reset();
    check("abort_valid", 192'(if16.packet_valid), 192'(0));
    check("abort_word", if16.audio_sample_word, '0);
    check("abort_present", 192'(if16.sample_present), 192'(0));
    check("abort_ready", 192'(if16.sample_ready), 192'(1));
    if16.packet_request = 1'b1;
    step();
    if16.packet_request = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      step();
      if (if16.packet_valid) seen = 1'b1;
    end
    check("abort_fifo_empty", 192'(seen), 192'(0));
    push16(16'hbeef, 16'hcafe);
    request16("abort_post", 1'b1);
    check("abort_frame0", 192'(if16.block_start), 192'(4'b0001));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/audio_sample_framer.md
Name: audio_sample_framer

Overview:
- Upstream feeder for the HDMI audio sample packet stage.
- Accepts stereo PCM samples synchronised to the pixel clock and buffers them in a small FIFO.
- When the packet picker offers a data-island slot, groups up to 4 buffered samples into one packet payload.
- Tags each sample with the IEC 60958 block-start (B) flag from a 192-frame counter, MSB-aligns samples into 24-bit fields, and hands off with valid/ack.

Parameters:
- AUDIO_BIT_WIDTH, 16, PCM sample width; legal values 16, 20, 24.
- FIFO_DEPTH, 8, sample FIFO depth in stereo frames; power of two, minimum 4.

Ports:
- clk_pixel  in  1  pixel clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- sample_valid  in  1  a stereo sample is offered this cycle.
- sample_left  in  AUDIO_BIT_WIDTH  left channel PCM, two's complement.
- sample_right  in  AUDIO_BIT_WIDTH  right channel PCM, two's complement.
- sample_ready  out  1  FIFO not full.
- overflow  out  1  sticky; a sample was offered while full.
- packet_request  in  1  one-cycle pulse: packet slot available.
- packet_valid  out  1  payload registers hold a complete packet.
- packet_ack  in  1  consumer has taken the packet.
- audio_sample_word  out  192  4 slots x {right[23:0], left[23:0]}; slot k occupies bits [48k+47:48k], left in the low 24 bits.
- sample_present  out  4  bit k set = slot k holds a sample.
- block_start  out  4  bit k set = slot k is frame 0 of a 192-frame block.

Behaviour:
- Reset values: sample_ready=1, overflow=0, packet_valid=0, audio_sample_word=0, sample_present=0, block_start=0; FIFO empty; frame counter=0; FSM=IDLE.
- Reset asserted at any point, including mid-LOAD or HOLD, aborts the packet, empties the FIFO and clears every state above on the next edge.
- Sample alignment: each channel becomes {sample, (24-AUDIO_BIT_WIDTH) zeros}, i.e. MSB-aligned. Example at 16 bits: 0x1234 -> 0x123400.
- FIFO push: on sample_valid && !full.
- FIFO overflow: sample_valid && full drops the sample and sets overflow. overflow stays set until reset.
- FIFO simultaneous push and pop in one cycle: count unchanged. A push while full and popping in the same cycle is accepted.
- sample_ready = !full, registered from count. It reflects the count after the edge.
- FSM, IDLE:
  - packet_request with count==0: stay IDLE; no packet_valid is produced.
  - packet_request with count>0: latch n=min(count,4), clear sample_present and block_start, then go to LOAD.
- FSM, LOAD:
  - Pops one sample per cycle into slot i, for i=0..n-1.
  - Sets sample_present[i].
  - Sets block_start[i] iff frame counter==0 at that pop.
  - Frame counter increments per pop and wraps 191->0.
  - After the n-th pop, go to HOLD.
  - Pushes arriving during LOAD do not extend n.
- FSM, HOLD:
  - packet_valid=1; payload is stable.
  - On packet_ack: packet_valid=0 on the next edge and return to IDLE. The payload registers keep their last values.
- Latency: request at edge t -> pops at t+1..t+n -> packet_valid high from t+n+1.
- packet_request while in LOAD or HOLD is ignored (not queued).
- packet_ack outside HOLD is ignored.
- packet_request and packet_ack in the same HOLD cycle: only the ack acts.
- Unused slots (index >= n) are zeroed when LOAD starts.
- Frame counter advances only on pops. Dropped samples do not advance it.

Test Plan:
- Reset: hold reset 3 cycles with sample_valid=1 -> all outputs at reset values, sample_ready=1, overflow=0; after release, the first pushed sample is accepted.
- Basic packet (16-bit): push L/R pairs 0x1234/0xABCD, 0x0001/0xFFFF, 0x7FFF/0x8000, then pulse packet_request.
  - Required: packet_valid rises exactly 4 cycles after the request.
  - sample_present=4'b0111, block_start=4'b0001.
  - Slot0 = {0xABCD00, 0x123400}; slot 3 = 0.
  - Ack -> packet_valid low next cycle.
- Empty request: pulse packet_request with FIFO empty -> packet_valid stays 0 for 20 cycles; FSM is back in IDLE and a later request with data works.
- Overflow: push 9 samples back-to-back with no pops.
  - Required: sample_ready=0 after the 8th push, overflow=1, 9th sample dropped.
  - Two request/ack rounds return samples 1-4 then 5-8 in order, each with sample_present=4'b1111.
- Block wrap: consume 190 samples, then push 4 and request -> block_start=4'b0100 (slot 2 is frame 0). The next block-start appears 192 samples later.
- Width and abort:
  - With AUDIO_BIT_WIDTH=20, sample 0xABCDE -> 0xABCDE0.
  - With AUDIO_BIT_WIDTH=24, sample 0x123456 -> 0x123456.
  - Reset asserted during HOLD -> packet_valid=0, FIFO empty, frame counter 0 on the next edge.
